// File: rtl/imem_loader.sv
// Byte-stream instruction loader: frames {count, words, xor checksum} into 16-bit imem writes.
// Write lands the cycle after INSTR_LO is accepted; in_ready drops outside an active frame.
module imem_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wd,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  state_t          state, state_nxt;
  logic            fire, go;
  logic [7:0]      cnt_hi, hi_byte, acc;
  logic [15:0]     n_word;
  logic [ADDR_W:0] count, wl_inc;

  assign n_word = {cnt_hi, in_data};
  assign wl_inc = words_loaded + {{ADDR_W{1'b0}}, 1'b1};
  assign fire   = in_valid & in_ready;

  always_comb begin
    in_ready = 1'b0;
    go       = 1'b0;
    case (state)
      S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CSUM: in_ready = 1'b1;
      default: go = start;
    endcase
    busy     = in_ready;
    cpu_hold = (state != S_DONE);
    done     = (state == S_DONE);
    error    = (state == S_ERROR);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (go) state_nxt = S_CNT_HI;
      S_CNT_HI:  if (fire) state_nxt = S_CNT_LO;
      S_CNT_LO: begin
        if (fire) begin
          if (n_word > DEPTH16)    state_nxt = S_ERROR;
          else if (n_word == 16'd0) state_nxt = S_CSUM;
          else                      state_nxt = S_DATA_HI;
        end
      end
      S_DATA_HI: if (fire) state_nxt = S_DATA_LO;
      S_DATA_LO: if (fire) state_nxt = (wl_inc == count) ? S_CSUM : S_DATA_HI;
      S_CSUM:    if (fire) state_nxt = (in_data == acc) ? S_DONE : S_ERROR;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Count bytes are excluded from the checksum; only instruction bytes fold into acc.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wd      <= '0;
      words_loaded <= '0;
      cnt_hi       <= '0;
      hi_byte      <= '0;
      acc          <= '0;
      count        <= '0;
    end else begin
      imem_we <= 1'b0;
      if (go) begin
        words_loaded <= '0;
        acc          <= '0;
      end
      if (fire) begin
        case (state)
          S_CNT_HI: cnt_hi <= in_data;
          S_CNT_LO: count  <= n_word[ADDR_W:0];
          S_DATA_HI: begin
            hi_byte <= in_data;
            acc     <= acc ^ in_data;
          end
          S_DATA_LO: begin
            imem_we      <= 1'b1;
            imem_addr    <= words_loaded[ADDR_W-1:0];
            imem_wd      <= {hi_byte, in_data};
            words_loaded <= wl_inc;
            acc          <= acc ^ in_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
